// File: rtl/status_ctrl_pkg.sv
// status_ctrl_pkg: shared widths, register addresses and clear-FSM states for status_irq_ctrl
package status_ctrl_pkg;
    localparam int               WIDTH       = 13;
    localparam logic [WIDTH-1:0] STICKY_MASK = 13'h126D;
    localparam logic [WIDTH-1:0] MASK_RST    = 13'h0000;
    localparam int               CLEAR_LAT   = 3;
    localparam int               CNT_W       = $clog2(CLEAR_LAT + 1);
    localparam logic [1:0]       ADDR_STATUS  = 2'd0;
    localparam logic [1:0]       ADDR_MASK    = 2'd1;
    localparam logic [1:0]       ADDR_CLEAR   = 2'd2;
    localparam logic [1:0]       ADDR_PENDING = 2'd3;
    typedef enum logic [1:0] {IDLE, CLR_REQ, CLR_WAIT, DONE} clr_state_t;
endpackage

// File: rtl/status_irq_ctrl_if.sv
// status_irq_ctrl_if: register-bus handshake between the core and status_irq_ctrl
interface status_irq_ctrl_if;
    import status_ctrl_pkg::*;
    logic             sel;
    logic             wen;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ready;
    modport master (output sel, wen, addr, wdata, input rdata, ready);
    modport slave  (input sel, wen, addr, wdata, output rdata, ready);
endinterface

// File: rtl/status_clr_seq.sv
// status_clr_seq: clear handshake; one-cycle clear pulse, CLEAR_LAT-cycle wait, then a done cycle
module status_clr_seq
    import status_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_clear,
    output logic o_done,
    output logic o_busy,
    output logic o_freeze
);
    clr_state_t       r_state;
    clr_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // State and latency counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_clear     = r_state == CLR_REQ;
        o_done      = r_state == DONE;
        o_busy      = r_state != IDLE;
        o_freeze    = (r_state == CLR_REQ) | (r_state == CLR_WAIT);
        case (r_state)
            IDLE:     if (i_start) w_state_nxt = CLR_REQ;
            CLR_REQ: begin
                w_state_nxt = CLR_WAIT;
                w_cnt_nxt   = '0;
            end
            CLR_WAIT: begin
                if (r_cnt == CNT_W'(CLEAR_LAT - 1)) w_state_nxt = DONE;
                else w_cnt_nxt = r_cnt + 1'b1;
            end
            default:  w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: rtl/status_irq_ctrl.sv
// status_irq_ctrl: bus front end for the status register; snapshots, masks sticky bits into irq, sequences clear
// Build option IRQ_EDGE_EN: irq becomes a one-cycle pulse per rising pending condition (default: registered level)
module status_irq_ctrl
    import status_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_status,
    status_irq_ctrl_if.slave bus,
    output logic             o_clear,
    output logic             o_irq
);
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_rdata;
    logic             r_ready;
    logic             r_irq;
    logic [WIDTH-1:0] w_pend_vec;
    logic [WIDTH-1:0] w_rd_mux;
    logic             w_pend;
    logic             w_accept;
    logic             w_is_clr;
    logic             w_is_mask;
    logic             w_busy;
    logic             w_done;
    logic             w_freeze;

    // A new access needs an idle sequencer and no ready pulse in the current cycle
    assign w_accept   = bus.sel & ~w_busy & ~r_ready;
    assign w_is_clr   = bus.wen & (bus.addr == ADDR_CLEAR);
    assign w_is_mask  = bus.wen & (bus.addr == ADDR_MASK);
    assign w_pend_vec = i_status & r_mask & STICKY_MASK;
    assign w_pend     = |w_pend_vec;
    assign w_rd_mux   = (bus.addr == ADDR_STATUS)  ? i_status :
                        (bus.addr == ADDR_MASK)    ? r_mask :
                        (bus.addr == ADDR_PENDING) ? w_pend_vec : '0;

    status_clr_seq u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept & w_is_clr),
        .o_clear  (o_clear),
        .o_done   (w_done),
        .o_busy   (w_busy),
        .o_freeze (w_freeze)
    );

    // Single-cycle accesses: ready pulse, read snapshot and mask register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_mask  <= MASK_RST;
        end else begin
            r_ready <= w_accept & ~w_is_clr;
            if (w_accept & ~bus.wen) r_rdata <= w_rd_mux;
            if (w_accept & w_is_mask) r_mask <= bus.wdata;
        end
    end

`ifdef IRQ_EDGE_EN
    logic r_pend_q;
    // Rising-edge irq pulse; sampling held while the clear handshake is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq    <= 1'b0;
            r_pend_q <= 1'b0;
        end else if (!w_freeze) begin
            r_irq    <= w_pend & ~r_pend_q;
            r_pend_q <= w_pend;
        end
    end
`else
    // Level irq; sampling held while the clear handshake is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_irq <= 1'b0;
        else if (!w_freeze) r_irq <= w_pend;
    end
`endif

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready | w_done;
    assign o_irq     = r_irq;
endmodule

// File: tb/tb_status_irq_ctrl.sv
// tb_status_irq_ctrl: randomized scoreboard bench for status_irq_ctrl with a behavioural reference model
module tb_status_irq_ctrl;
    import status_ctrl_pkg::*;

    typedef struct {
        bit               rd;
        logic [WIDTH-1:0] data;
        int               at;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    wire  [WIDTH-1:0] i_status;
    logic             o_clear;
    logic             o_irq;

    status_irq_ctrl_if bus();

    status_irq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .i_status (i_status),
        .bus      (bus),
        .o_clear  (o_clear),
        .o_irq    (o_irq)
    );

    always #5 clk = ~clk;

    int               cyc = 0;
    int               errs = 0;
    int               checks = 0;
    exp_t             q[$];
    exp_t             it_m;
    logic [WIDTH-1:0] st = '0;
    logic [WIDTH-1:0] st_drv = '0;
    int               st_set_at = 0;
    int               clr_seen_at = -1;
    logic [WIDTH-1:0] m_sb = MASK_RST;
    logic [WIDTH-1:0] m_irq = MASK_RST;
    logic [WIDTH-1:0] upd_val = '0;
    int               upd_at = -1;
    int               clr_at = -100;
    int               free_at = 0;
    logic             e_irq = 1'b0;
    logic             e_prev = 1'b0;
    logic [WIDTH-1:0] last_rd = '0;
    logic [WIDTH-1:0] s_edge;
    logic             m_pend;
    bit               m_frz;

    // Status register emulation: sticky bits read back cleared CLEAR_LAT cycles after a clear pulse
    assign i_status = (clr_seen_at > st_set_at && cyc >= clr_seen_at + CLEAR_LAT) ? (st_drv & ~STICKY_MASK) : st_drv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_status(input logic [WIDTH-1:0] v);
        @(negedge clk);
        st_drv    = v;
        st_set_at = cyc;
        st        = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        bus.sel  = 1'b1;
        bus.wen  = 1'b0;
        bus.addr = ADDR_MASK;
        #1;
        chk("rst_clear", o_clear, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_irq", o_irq, 0);
        chk("rst_rdata", bus.rdata, 0);
        q.delete();
        m_sb    = MASK_RST;
        m_irq   = MASK_RST;
        upd_at  = -1;
        clr_at  = -100;
        free_at = 0;
        e_irq   = 1'b0;
        e_prev  = 1'b0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        bus.sel = 1'b0;
    endtask

    // Issue one access; the model decides when it is accepted and when ready must appear
    task automatic do_acc(input bit w, input logic [1:0] a, input logic [WIDTH-1:0] d, input bit wt);
        exp_t it;
        int   acc;
        @(negedge clk);
        acc     = (cyc + 1 > free_at) ? cyc + 1 : free_at;
        it.rd   = !w;
        it.data = (a == ADDR_STATUS)  ? st :
                  (a == ADDR_MASK)    ? m_sb :
                  (a == ADDR_PENDING) ? (st & m_sb & STICKY_MASK) : '0;
        it.at   = acc + ((w && a == ADDR_CLEAR) ? CLEAR_LAT + 1 : 0);
        free_at = it.at + 2;
        if (w && a == ADDR_MASK) begin
            m_sb    = d;
            upd_at  = acc;
            upd_val = d;
        end
        if (w && a == ADDR_CLEAR) begin
            clr_at = acc;
            st     = st & ~STICKY_MASK;
        end
        q.push_back(it);
        bus.sel   = 1'b1;
        bus.wen   = w;
        bus.addr  = a;
        bus.wdata = d;
        while (cyc < (wt ? it.at : acc)) @(negedge clk);
        bus.sel = 1'b0;
    endtask

    // Monitor: per-cycle irq/clear model plus scoreboard pop on every ready pulse
    initial forever begin
        @(posedge clk);
        s_edge = i_status;
        #1;
        cyc++;
        if (!rst) begin
            m_frz  = cyc > clr_at && cyc <= clr_at + CLEAR_LAT + 1;
            m_pend = |(s_edge & m_irq & STICKY_MASK);
`ifdef IRQ_EDGE_EN
            if (!m_frz) begin
                e_irq  = m_pend & ~e_prev;
                e_prev = m_pend;
            end
`else
            if (!m_frz) e_irq = m_pend;
`endif
            chk("irq", o_irq, e_irq);
            chk("clear", o_clear, cyc == clr_at);
            if (o_clear) clr_seen_at = cyc;
            if (cyc == upd_at) m_irq = upd_val;
            if (bus.ready) begin
                if (q.size() == 0) chk("spurious_ready", bus.ready, 0);
                else begin
                    it_m = q.pop_front();
                    chk("ready_cycle", cyc, it_m.at);
                    if (it_m.rd) begin
                        chk("rdata", bus.rdata, it_m.data);
                        last_rd = it_m.data;
                    end else chk("rdata_hold", bus.rdata, last_rd);
                end
            end else if (q.size() > 0 && q[0].at <= cyc) begin
                chk("ready_missing", bus.ready, 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        bus.sel   = 1'b0;
        bus.wen   = 1'b0;
        bus.addr  = ADDR_STATUS;
        bus.wdata = '0;
        do_reset();
        do_acc(0, ADDR_MASK, '0, 1);
        do_acc(1, ADDR_MASK, 13'h0001, 1);
        set_status(13'h0001);
        repeat (3) @(negedge clk);
        do_acc(1, ADDR_MASK, 13'h1FFF, 1);
        set_status(13'h0002);
        repeat (3) @(negedge clk);
        set_status(13'h1FFF);
        do_acc(1, ADDR_CLEAR, 13'h1555, 0);
        do_acc(0, ADDR_STATUS, '0, 1);
        set_status(13'h1FFF);
        do_acc(1, ADDR_MASK, 13'h0F0F, 1);
        do_acc(0, ADDR_PENDING, '0, 1);
        do_acc(1, ADDR_CLEAR, '0, 0);
        @(negedge clk);
        do_reset();
        do_acc(1, ADDR_CLEAR, '0, 1);
        do_acc(1, ADDR_MASK, 13'h0008, 1);
        set_status(13'h0008);
        repeat (6) @(negedge clk);
        do_acc(1, ADDR_STATUS, 13'h1FFF, 1);
        do_acc(1, ADDR_PENDING, 13'h1FFF, 1);
        do_acc(0, ADDR_CLEAR, '0, 1);
        repeat (300) begin
            if ($urandom_range(3) == 0) set_status(13'($urandom));
            do_acc(1'($urandom_range(1)), 2'($urandom_range(3)), 13'($urandom), 1);
        end
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
